rx_fifo_ctrl: RTL and testbench

- Downstream consumer of the UART receiver top level.
- Watches the receiver's data_ready and captures rx_data plus its error flags into a DEPTH-entry FIFO.
- Pulses data_read back to the receiver to release its one-byte buffer.
- Presents queued bytes to the host side on a valid/ready interface, so the receiver's single-byte buffer no longer overruns during host latency.

---
 rtl/rx_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_rx_fifo_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_ctrl.sv
// rx_fifo_ctrl: buffers bytes from the UART receiver into a DEPTH-entry FIFO
// and hands them to the host on a valid/ready port.
// Optional RX_FIFO_DROP_FERR_EN: acknowledge but discard bytes with framing errors.
module rx_fifo_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     data_ready,
  input  logic                     framing_error,
  input  logic                     overrun_error,
  output logic                     data_read,
  output logic [7:0]               out_data,
  output logic                     out_ferr,
  output logic                     out_ovr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     lost_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          capture;
  logic          wr_en;
  logic          pop;
  logic [CW-1:0] count_next;

  always_comb begin
    capture = (state == IDLE) && data_ready && !full;
`ifdef RX_FIFO_DROP_FERR_EN
    wr_en = capture && !framing_error;
`else
    wr_en = capture;
`endif
    pop        = out_valid && out_ready;
    count_next = count + CW'(wr_en) - CW'(pop);
  end

  // ACK and HOLD give the receiver time to drop data_ready before we look again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (capture) state <= ACK;
        ACK:     state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_read = (state == ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      lost_flag   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      full        <= (count_next == CW'(DEPTH));
      almost_full <= (count_next >= CW'(AFULL_LVL));
      if (capture && overrun_error) lost_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= {overrun_error, framing_error, rx_data};
  end

  // Head is gated by out_valid so stale storage never leaks out after reset.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_ovr   = out_valid ? mem[rd_ptr][9]   : 1'b0;
`ifdef RX_FIFO_DROP_FERR_EN
  assign out_ferr  = 1'b0;
`else
  assign out_ferr  = out_valid ? mem[rd_ptr][8]   : 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// tb_rx_fifo_ctrl: directed and randomized checks of rx_fifo_ctrl against a
// queue-based reference model of the capture/pop rules.
module tb_rx_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;
  logic       data_read;
  logic [7:0] out_data;
  logic       out_ferr;
  logic       out_ovr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       full;
  logic       almost_full;
  logic       lost_flag;

  rx_fifo_ctrl #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(data_read), .out_data(out_data), .out_ferr(out_ferr),
    .out_ovr(out_ovr), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .almost_full(almost_full), .lost_flag(lost_flag)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents, cycles until the next capture is allowed,
  // expected receiver acknowledge and sticky lost flag.
  logic [9:0] q[$];
  int         cool;
  bit         exp_dr;
  bit         lost;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    cool   = 0;
    exp_dr = 0;
    lost   = 0;
  endtask

  task automatic modelEdge();
    bit do_pop;
    bit do_cap;
    do_pop = (q.size() != 0) && out_ready;
    do_cap = data_ready && (cool == 0) && (q.size() != DEPTH);
    if (do_pop) void'(q.pop_front());
`ifdef RX_FIFO_DROP_FERR_EN
    if (do_cap && !framing_error) q.push_back({overrun_error, 1'b0, rx_data});
`else
    if (do_cap) q.push_back({overrun_error, framing_error, rx_data});
`endif
    if (do_cap && overrun_error) lost = 1;
    exp_dr = do_cap;
    if (do_cap) cool = 2;
    else if (cool > 0) cool--;
  endtask

  task automatic compareAll();
    checkOutput("data_read", data_read, exp_dr);
    checkOutput("out_valid", out_valid, q.size() != 0);
    checkOutput("count", count, q.size());
    checkOutput("full", full, q.size() == DEPTH);
    checkOutput("almost_full", almost_full, q.size() >= AFULL);
    checkOutput("lost_flag", lost_flag, lost);
    if (q.size() != 0) begin
      checkOutput("head_data", out_data, q[0][7:0]);
      checkOutput("head_ferr", out_ferr, q[0][8]);
      checkOutput("head_ovr", out_ovr, q[0][9]);
    end else begin
      checkOutput("idle_data", out_data, 8'h00);
    end
  endtask

  // One clock: model the edge, check #1 later, then let the receiver react.
  // mode 0: receiver frozen, 1: release on data_read, 2: also offer random bytes.
  task automatic applyStimulus(input bit do_rst, input int mode);
    rst = do_rst;
    @(posedge clk);
    if (do_rst) modelReset();
    else modelEdge();
    #1;
    compareAll();
    if (mode >= 1 && data_read && data_ready) data_ready = 1'b0;
    if (mode == 2 && !data_ready && $urandom_range(3) == 0) begin
      rx_data       = 8'($urandom);
      framing_error = ($urandom_range(7) == 0);
      overrun_error = ($urandom_range(7) == 0);
      data_ready    = 1'b1;
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input bit ferr, input bit ovr);
    bit released;
    rx_data       = d;
    framing_error = ferr;
    overrun_error = ovr;
    data_ready    = 1'b1;
    released      = 0;
    for (int i = 0; i < 20 && !released; i++) begin
      applyStimulus(0, 1);
      released = !data_ready;
    end
    checkOutput("send_done", released, 1'b1);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    framing_error = 1'b0;
    overrun_error = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; data_ready = 1'b0;
    framing_error = 1'b0; overrun_error = 1'b0; out_ready = 1'b0;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_valid", out_valid, 0);

    // single byte: ack pulse one cycle after capture, head visible immediately
    rx_data = 8'hA5; data_ready = 1'b1;
    applyStimulus(0, 0);
    checkOutput("a5_head", out_data, 8'hA5);
    checkOutput("a5_ack", data_read, 1'b1);
    data_ready = 1'b0;
    applyStimulus(0, 0);
    checkOutput("a5_ack_end", data_read, 1'b0);
    applyStimulus(0, 0);

    // fill, blocked ninth byte, release by one pop, then drain
    applyStimulus(1, 0);
    for (int i = 1; i <= 8; i++) sendByte(8'(i), 1'b0, 1'b0);
    checkOutput("fill_full", full, 1'b1);
    rx_data = 8'h09; data_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(0, 1);
    checkOutput("blocked", data_ready, 1'b1);
    out_ready = 1'b1;
    applyStimulus(0, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1);
    checkOutput("ninth_taken", data_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(0, 1);
    checkOutput("drained", count, 0);
    out_ready = 1'b0;

    // simultaneous pop and capture at count 3
    applyStimulus(1, 0);
    for (int i = 0; i < 3; i++) sendByte(8'h10 + 8'(i), 1'b0, 1'b0);
    rx_data = 8'hAA; data_ready = 1'b1; out_ready = 1'b1;
    applyStimulus(0, 0);
    out_ready = 1'b0; data_ready = 1'b0;
    checkOutput("simul_count", count, 3);
    applyStimulus(0, 0);
    applyStimulus(0, 0);

    // error flags
    applyStimulus(1, 0);
    sendByte(8'h3C, 1'b1, 1'b0);
    sendByte(8'h55, 1'b0, 1'b1);
    checkOutput("err_lost", lost_flag, 1'b1);

    // reset while acknowledging; pending byte is captured once afterwards
    applyStimulus(1, 0);
    rx_data = 8'h77; data_ready = 1'b1;
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    checkOutput("rst_ack_dr", data_read, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1);
    checkOutput("rst_recap", count, 1);

    // randomized traffic under light, medium and heavy host readiness
    for (int p = 0; p < 3; p++) begin
      int pct;
      pct = (p == 0) ? 10 : (p == 1) ? 50 : 90;
      for (int i = 0; i < 1500; i++) begin
        out_ready = ($urandom_range(99) < pct);
        applyStimulus($urandom_range(299) == 0, 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
